// File: rtl/btn_debounce_pkg.sv
// ---------------------------------------------------------------------------
// btn_debounce_pkg
// Shared constants for the multi-channel button debouncer.
//   NCH_MAX           : largest supported channel count
//   *_25MHZ           : default timing values for a 25 MHz system clock
//   cnt_width(n)      : bits needed for a counter holding 0..n-1 (min 1)
// ---------------------------------------------------------------------------
package btn_debounce_pkg;

  localparam int NCH_MAX         = 32;
  localparam int PRESCALE_25MHZ  = 250;    // 10 us tick
  localparam int DB_TICKS_25MHZ  = 1000;   // 10 ms qualification
  localparam int REP_DELAY_25MHZ = 50000;  // 500 ms before first repeat
  localparam int REP_RATE_25MHZ  = 10000;  // 100 ms between repeats

  // Never returns 0, so a degenerate count of 1 still gets a real register.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_multi_if.sv
// ---------------------------------------------------------------------------
// btn_debounce_multi_if
// Bundles the button inputs and debounced outputs of btn_debounce_multi.
//   btn_i  : raw asynchronous button levels (driven by the board side)
//   o      : debounced levels
//   rise_o : one-cycle strobe on a 0->1 change of o
//   fall_o : one-cycle strobe on a 1->0 change of o
//   rep_o  : one-cycle auto-repeat strobe
//   tick_o : shared prescaler tick
// Modports: master = board/consumer side, slave = debouncer.
// ---------------------------------------------------------------------------
interface btn_debounce_multi_if #(
  parameter int NCH = 4
);

  logic [NCH-1:0] btn_i;
  logic [NCH-1:0] o;
  logic [NCH-1:0] rise_o;
  logic [NCH-1:0] fall_o;
  logic [NCH-1:0] rep_o;
  logic           tick_o;

  modport master (output btn_i, input o, rise_o, fall_o, rep_o, tick_o);
  modport slave  (input btn_i, output o, rise_o, fall_o, rep_o, tick_o);

endinterface

// File: rtl/btn_debounce_chan.sv
// ---------------------------------------------------------------------------
// btn_debounce_chan
// One debouncer channel: two-flop synchroniser, tick-based stability
// counter, debounced level with rise/fall strobes and, when the macro
// BTN_DEBOUNCE_REPEAT_EN is defined, an auto-repeat counter.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   tick_i   : shared debounce tick (one clk wide)
//   btn_i    : raw asynchronous button level
//   lvl_o    : debounced level
//   rise_o   : registered strobe coincident with lvl_o going 0->1
//   fall_o   : registered strobe coincident with lvl_o going 1->0
//   rep_o    : auto-repeat strobe aligned with tick_i (0 without the macro)
// ---------------------------------------------------------------------------
module btn_debounce_chan
  import btn_debounce_pkg::*;
#(
  parameter int   DB_TICKS  = DB_TICKS_25MHZ,
  parameter logic RST_VAL   = 1'b0,
  parameter int   REP_DELAY = REP_DELAY_25MHZ,
  parameter int   REP_RATE  = REP_RATE_25MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic btn_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o,
  output logic rep_o
);

  localparam int            CW       = cnt_width(DB_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronised input agrees with the output throws
  // away the accumulated progress, so only an unbroken run of disagreeing
  // ticks can flip the level.
  always_comb begin
    lvl_d  = lvl_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s2_q == lvl_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d  = s2_q;
        cnt_d  = '0;
        rise_d = s2_q;
        fall_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      lvl_q  <= RST_VAL;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= btn_i;
      s2_q   <= s1_q;
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam int            RW        = cnt_width((REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE);
  localparam logic [RW-1:0] REP_FIRST = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REP_RATE - 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_arm_q, rep_arm_d;
  logic          rep_hit;
  logic          fall_now;

  // rep_arm_q separates the long initial delay from the shorter repeat
  // period; the counter restarts from zero after every pulse.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_arm_d = rep_arm_q;
    rep_hit   = (rep_cnt_q == (rep_arm_q ? REP_NEXT : REP_FIRST));
    if (!lvl_q || rise_q) begin
      rep_cnt_d = '0;
      rep_arm_d = 1'b0;
    end else if (tick_i) begin
      if (rep_hit) begin
        rep_cnt_d = '0;
        rep_arm_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q <= '0;
      rep_arm_q <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_arm_q <= rep_arm_d;
    end
  end

  // Decoded from registers so the pulse lands in the tick cycle itself; a
  // tick that commits a release is suppressed so no repeat races the fall.
  assign fall_now = (s2_q != lvl_q) && (cnt_q == CNT_LAST);
  assign rep_o    = tick_i & lvl_q & ~rise_q & rep_hit & ~fall_now;
`else
  assign rep_o = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_multi.sv
// ---------------------------------------------------------------------------
// btn_debounce_multi
// N-channel button/switch debouncer with a shared prescaler tick.
// Optional auto-repeat is compiled in with the macro BTN_DEBOUNCE_REPEAT_EN.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : btn_debounce_multi_if.slave (btn_i in; o, rise_o, fall_o, rep_o,
//         tick_o out)
// ---------------------------------------------------------------------------
module btn_debounce_multi
  import btn_debounce_pkg::*;
#(
  parameter int   NCH       = 4,
  parameter int   PRESCALE  = PRESCALE_25MHZ,
  parameter int   DB_TICKS  = DB_TICKS_25MHZ,
  parameter logic RST_VAL   = 1'b0,
  parameter int   REP_DELAY = REP_DELAY_25MHZ,
  parameter int   REP_RATE  = REP_RATE_25MHZ
) (
  input  logic                 clk,
  input  logic                 rst,
  btn_debounce_multi_if.slave  bus
);

  localparam int            PW       = cnt_width(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]  pre_cnt_q, pre_cnt_d;
  logic           tick_q, tick_d;
  logic [NCH-1:0] lvl, rise, fall, rep;

  // Tick is registered from the terminal count, so with PRESCALE=1 it is
  // simply high on every cycle after the first edge out of reset.
  always_comb begin
    tick_d    = (pre_cnt_q == PRE_LAST);
    pre_cnt_d = tick_d ? '0 : pre_cnt_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      tick_q    <= tick_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    btn_debounce_chan #(
      .DB_TICKS  (DB_TICKS),
      .RST_VAL   (RST_VAL),
      .REP_DELAY (REP_DELAY),
      .REP_RATE  (REP_RATE)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .tick_i (tick_q),
      .btn_i  (bus.btn_i[g]),
      .lvl_o  (lvl[g]),
      .rise_o (rise[g]),
      .fall_o (fall[g]),
      .rep_o  (rep[g])
    );
  end

  assign bus.o      = lvl;
  assign bus.rise_o = rise;
  assign bus.fall_o = fall;
  assign bus.rep_o  = rep;
  assign bus.tick_o = tick_q;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce_multi
// Directed bench for btn_debounce_multi with NCH=4, PRESCALE=4, DB_TICKS=3,
// REP_DELAY=5, REP_RATE=2. Repeat checks follow BTN_DEBOUNCE_REPEAT_EN.
// ---------------------------------------------------------------------------
module tb_btn_debounce_multi;

  localparam int NCH       = 4;
  localparam int PRESCALE  = 4;
  localparam int DB_TICKS  = 3;
  localparam int REP_DELAY = 5;
  localparam int REP_RATE  = 2;

  logic clk;
  logic rst;

  btn_debounce_multi_if #(.NCH(NCH)) bus ();

  btn_debounce_multi #(
    .NCH       (NCH),
    .PRESCALE  (PRESCALE),
    .DB_TICKS  (DB_TICKS),
    .RST_VAL   (1'b0),
    .REP_DELAY (REP_DELAY),
    .REP_RATE  (REP_RATE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int             total = 0;
  int             bad = 0;
  int             cyc = 0;
  int             lastTick = -1;
  int             riseCnt [NCH] = '{default: 0};
  int             fallCnt [NCH] = '{default: 0};
  int             repCnt [NCH] = '{default: 0};
  logic [NCH-1:0] prevO = '0;
  logic           repSeen = 1'b0;
  logic           stayLow;
  int             lat;
  int             riseSum, fallSum;
`ifdef BTN_DEBOUNCE_REPEAT_EN
  logic [15:0]    repMask;
  int             tickNum;
  logic           offTickRep;
  int             repSnap;
`endif

  // One comparison: count it, report it when it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    total++;
    if (got !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] v);
    bus.btn_i = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until o[ch] reaches lvl; lat is the number of edges taken, -1 on timeout.
  task automatic waitLevel(input int ch, input logic lvl, input int limit, output int latOut);
    latOut = -1;
    for (int n = 1; n <= limit; n++) begin
      step();
      if (bus.o[ch] === lvl) begin
        latOut = n;
        return;
      end
    end
  endtask

  // Mid-cycle monitor: strobes must match level changes, ticks must be
  // exactly PRESCALE apart, and pulse counts are kept per channel.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prevO    = bus.o;
      lastTick = -1;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.rise_o[i]) riseCnt[i]++;
        if (bus.fall_o[i]) fallCnt[i]++;
        if (bus.rep_o[i])  repCnt[i]++;
        if (bus.rise_o[i] || bus.fall_o[i] || (bus.o[i] !== prevO[i]))
          checkOutput($sformatf("strobe_vs_level_ch%0d", i),
                      {30'd0, bus.rise_o[i], bus.fall_o[i]},
                      {30'd0, ~prevO[i] & bus.o[i], prevO[i] & ~bus.o[i]});
      end
      if (bus.tick_o) begin
        if (lastTick >= 0) checkOutput("tick_period", cyc - lastTick, PRESCALE);
        lastTick = cyc;
      end
      if (bus.rep_o != '0) repSeen = 1'b1;
      prevO = bus.o;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    applyStimulus('0);
    #2 rst = 1'b1;
    repeat (3) step();
    checkOutput("reset_o", bus.o, 0);
    checkOutput("reset_rise", bus.rise_o, 0);
    checkOutput("reset_fall", bus.fall_o, 0);
    checkOutput("reset_rep", bus.rep_o, 0);
    checkOutput("reset_tick", bus.tick_o, 0);
    rst = 1'b0;
    repeat (12) step();

    // Clean press on channel 0
    applyStimulus(4'b0001);
    waitLevel(0, 1'b1, 40, lat);
    $display("[TB] press latency %0d", lat);
    checkOutput("press_latency_11_14", (lat >= 11 && lat <= 14), 1);
    checkOutput("press_rise", bus.rise_o, 4'b0001);
    checkOutput("press_levels", bus.o, 4'b0001);
    step();
    checkOutput("press_rise_one_cycle", bus.rise_o, 0);

    // Bounce on channel 1: toggle every 5 clk for 100 clk, then hold high
    stayLow = 1'b1;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(bus.btn_i ^ 4'b0010);
      for (int j = 0; j < 5; j++) begin
        step();
        if (bus.o[1] !== 1'b0) stayLow = 1'b0;
      end
    end
    checkOutput("bounce_o1_low", stayLow, 1);
    applyStimulus(bus.btn_i | 4'b0010);
    waitLevel(1, 1'b1, 40, lat);
    checkOutput("bounce_latency_11_14", (lat >= 11 && lat <= 14), 1);
    checkOutput("bounce_rise", bus.rise_o, 4'b0010);
    repeat (20) step();
    checkOutput("bounce_rise_count", riseCnt[1], 1);
    checkOutput("bounce_fall_count", fallCnt[1], 0);

    // Press then release channel 2
    applyStimulus(bus.btn_i | 4'b0100);
    waitLevel(2, 1'b1, 40, lat);
    checkOutput("ch2_press_rise", bus.rise_o, 4'b0100);
    repeat (5) step();
    applyStimulus(bus.btn_i & 4'b1011);
    waitLevel(2, 1'b0, 40, lat);
    checkOutput("release_latency_11_14", (lat >= 11 && lat <= 14), 1);
    checkOutput("release_fall", bus.fall_o, 4'b0100);
    step();
    checkOutput("release_fall_one_cycle", bus.fall_o, 0);
    repeat (20) step();
    checkOutput("release_fall_count", fallCnt[2], 1);

    // Simultaneous press on all channels
    applyStimulus('0);
    repeat (30) step();
    checkOutput("all_released", bus.o, 0);
    applyStimulus(4'hF);
    waitLevel(3, 1'b1, 40, lat);
    checkOutput("simul_latency_11_14", (lat >= 11 && lat <= 14), 1);
    checkOutput("simul_rise", bus.rise_o, 4'hF);
    checkOutput("simul_levels", bus.o, 4'hF);

`ifdef BTN_DEBOUNCE_REPEAT_EN
    // Repeat pulses expected at ticks 5, 7, 9 after the rise
    repMask    = '0;
    tickNum    = 0;
    offTickRep = 1'b0;
    for (int n = 0; n < 60 && tickNum < 10; n++) begin
      step();
      if (bus.tick_o) begin
        tickNum++;
        if (bus.rep_o[3]) repMask[tickNum] = 1'b1;
      end else if (bus.rep_o != '0) begin
        offTickRep = 1'b1;
      end
    end
    checkOutput("rep_tick_pattern", repMask, 16'h02A0);
    checkOutput("rep_only_on_tick", offTickRep, 0);
    applyStimulus('0);
    waitLevel(3, 1'b0, 40, lat);
    repSnap = repCnt[3];
    repeat (40) step();
    checkOutput("rep_stops_after_fall", repCnt[3], repSnap);
`else
    repeat (60) step();
    applyStimulus('0);
    waitLevel(3, 1'b0, 40, lat);
    repeat (10) step();
    checkOutput("rep_never_without_feature", repSeen, 0);
`endif
    checkOutput("rep_idle_after_release", bus.rep_o, 0);

    // Asynchronous reset in the middle of a run with all buttons held
    applyStimulus(4'hF);
    waitLevel(0, 1'b1, 40, lat);
    checkOutput("pre_reset_levels", bus.o, 4'hF);
    repeat (3) step();
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_o", bus.o, 0);
    checkOutput("async_reset_rise", bus.rise_o, 0);
    checkOutput("async_reset_fall", bus.fall_o, 0);
    checkOutput("async_reset_rep", bus.rep_o, 0);
    checkOutput("async_reset_tick", bus.tick_o, 0);
    repeat (2) step();
    riseSum = riseCnt[0] + riseCnt[1] + riseCnt[2] + riseCnt[3];
    fallSum = fallCnt[0] + fallCnt[1] + fallCnt[2] + fallCnt[3];
    rst = 1'b0;
    waitLevel(0, 1'b1, 40, lat);
    checkOutput("post_reset_latency", lat, 13);
    checkOutput("post_reset_rise", bus.rise_o, 4'hF);
    repeat (2) step();
    checkOutput("post_reset_rise_total", riseCnt[0] + riseCnt[1] + riseCnt[2] + riseCnt[3] - riseSum, 4);
    checkOutput("post_reset_no_fall", fallCnt[0] + fallCnt[1] + fallCnt[2] + fallCnt[3] - fallSum, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
